// File: rtl/mem_arb_pkg.sv
// mem_arb_pkg: shared types and constants for the IF/MEM unified-memory arbiter.
//   arb_state_t          : IDLE (nothing outstanding) / WAIT (one transaction outstanding)
//   arb_owner_t          : which stage owns the outstanding transaction
//   STARVE_LIMIT_DEFAULT : default number of consecutive DM grants tolerated
//                          while a fetch is waiting
package mem_arb_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    WAIT = 1'b1
  } arb_state_t;

  typedef enum logic [1:0] {
    OWN_NONE = 2'd0,
    OWN_IF   = 2'd1,
    OWN_DM   = 2'd2
  } arb_owner_t;

  localparam int STARVE_LIMIT_DEFAULT = 4;

endpackage

// File: rtl/arb_starve_counter.sv
// arb_starve_counter: 4-bit saturating counter of consecutive DM grants
// taken while a fetch is pending.
//   clk, rst       : clock, asynchronous active-low reset
//   inc            : count one DM grant (saturates at LIMIT)
//   clr            : clear (IF grant, or no fetch pending); wins over inc
//   limit_reached  : counter equals LIMIT, IF must win the next tie
module arb_starve_counter #(
  parameter int LIMIT = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic inc,
  input  logic clr,
  output logic limit_reached
);

  localparam logic [3:0] LIMIT_C = 4'(LIMIT);

  logic [3:0] cnt_q;
  logic [3:0] cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr) begin
      cnt_d = 4'd0;
    end else if (inc && (cnt_q != LIMIT_C)) begin
      cnt_d = cnt_q + 4'd1;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt_q <= 4'd0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign limit_reached = (cnt_q == LIMIT_C);

endmodule

// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: shares one single-port memory between instruction fetch
// (IF) and load/store (DM). One transaction outstanding at most.
//   clk, rst            : clock, asynchronous active-low reset
//   if_req_* / if_rsp_* : fetch request (valid/ready) and registered response
//   dm_req_* / dm_rsp_* : data request (valid/ready) and registered response
//   mem_req_* / mem_rsp_*: memory-side request and response
//   arb_err             : sticky, a memory response arrived while idle
//   dbg_state           : current FSM state
// Optional feature macro: MEM_ARB_STARVE_GUARD_EN builds the starvation guard
// (after STARVE_LIMIT consecutive DM grants with a fetch waiting, IF wins the
// next tie). Without it DM has strict priority.
//
// Handshake: a request transfers in any cycle where valid and ready are both
// high; the requester holds valid and its fields stable until then. The
// selection is recomputed every cycle, so a not-yet-accepted grant may move.
module mem_port_arbiter
  import mem_arb_pkg::*;
#(
  parameter int ADDR_W       = 32,
  parameter int DATA_W       = 32,
  parameter int STARVE_LIMIT = STARVE_LIMIT_DEFAULT
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              if_req_valid,
  input  logic [ADDR_W-1:0] if_req_addr,
  output logic              if_req_ready,
  output logic              if_rsp_valid,
  output logic [DATA_W-1:0] if_rsp_data,
  input  logic              dm_req_valid,
  input  logic              dm_req_we,
  input  logic [ADDR_W-1:0] dm_req_addr,
  input  logic [DATA_W-1:0] dm_req_wdata,
  output logic              dm_req_ready,
  output logic              dm_rsp_valid,
  output logic [DATA_W-1:0] dm_rsp_rdata,
  output logic              mem_req_valid,
  output logic              mem_req_we,
  output logic [ADDR_W-1:0] mem_req_addr,
  output logic [DATA_W-1:0] mem_req_wdata,
  input  logic              mem_req_ready,
  input  logic              mem_rsp_valid,
  input  logic [DATA_W-1:0] mem_rsp_rdata,
  output logic              arb_err,
  output arb_state_t        dbg_state
);

  arb_state_t        state_q, state_d;
  arb_owner_t        owner_q, owner_d;
  logic              we_q, we_d;
  logic              if_rsp_valid_q, if_rsp_valid_d;
  logic [DATA_W-1:0] if_rsp_data_q, if_rsp_data_d;
  logic              dm_rsp_valid_q, dm_rsp_valid_d;
  logic [DATA_W-1:0] dm_rsp_rdata_q, dm_rsp_rdata_d;
  logic              arb_err_q, arb_err_d;

  logic sel_if, sel_dm;
  logic grant_if, grant_dm;
  logic starve_hit;

`ifdef MEM_ARB_STARVE_GUARD_EN
  // A cycle without a pending fetch breaks the "consecutive" run.
  arb_starve_counter #(
    .LIMIT(STARVE_LIMIT)
  ) u_starve (
    .clk          (clk),
    .rst          (rst),
    .inc          (grant_dm & if_req_valid),
    .clr          (grant_if | ~if_req_valid),
    .limit_reached(starve_hit)
  );
`else
  localparam int unused_starve_limit = STARVE_LIMIT;
  assign starve_hit = 1'b0;
`endif

  // Selection only exists in IDLE; in WAIT every request output is zero.
  always_comb begin
    sel_if = 1'b0;
    sel_dm = 1'b0;
    if (state_q == IDLE) begin
      if (if_req_valid && dm_req_valid) begin
        sel_if = starve_hit;
        sel_dm = ~starve_hit;
      end else begin
        sel_if = if_req_valid;
        sel_dm = dm_req_valid;
      end
    end
  end

  assign mem_req_valid = sel_if | sel_dm;
  assign mem_req_we    = sel_dm & dm_req_we;
  assign mem_req_addr  = sel_dm ? dm_req_addr : (sel_if ? if_req_addr : '0);
  assign mem_req_wdata = sel_dm ? dm_req_wdata : '0;
  assign if_req_ready  = sel_if & mem_req_ready;
  assign dm_req_ready  = sel_dm & mem_req_ready;
  assign grant_if      = if_req_ready;
  assign grant_dm      = dm_req_ready;

  always_comb begin
    state_d        = state_q;
    owner_d        = owner_q;
    we_d           = we_q;
    if_rsp_valid_d = 1'b0;
    if_rsp_data_d  = if_rsp_data_q;
    dm_rsp_valid_d = 1'b0;
    dm_rsp_rdata_d = dm_rsp_rdata_q;
    arb_err_d      = arb_err_q;
    case (state_q)
      IDLE: begin
        // No owner: a response here has nowhere to go.
        if (mem_rsp_valid) begin
          arb_err_d = 1'b1;
        end
        if (grant_if || grant_dm) begin
          state_d = WAIT;
          owner_d = grant_if ? OWN_IF : OWN_DM;
          we_d    = grant_dm & dm_req_we;
        end
      end
      WAIT: begin
        if (mem_rsp_valid) begin
          if (owner_q == OWN_IF) begin
            if_rsp_valid_d = 1'b1;
            if_rsp_data_d  = mem_rsp_rdata;
          end else begin
            dm_rsp_valid_d = 1'b1;
            dm_rsp_rdata_d = we_q ? '0 : mem_rsp_rdata;
          end
          state_d = IDLE;
          owner_d = OWN_NONE;
          we_d    = 1'b0;
        end
      end
      default: begin
        state_d = IDLE;
        owner_d = OWN_NONE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q        <= IDLE;
      owner_q        <= OWN_NONE;
      we_q           <= 1'b0;
      if_rsp_valid_q <= 1'b0;
      if_rsp_data_q  <= '0;
      dm_rsp_valid_q <= 1'b0;
      dm_rsp_rdata_q <= '0;
      arb_err_q      <= 1'b0;
    end else begin
      state_q        <= state_d;
      owner_q        <= owner_d;
      we_q           <= we_d;
      if_rsp_valid_q <= if_rsp_valid_d;
      if_rsp_data_q  <= if_rsp_data_d;
      dm_rsp_valid_q <= dm_rsp_valid_d;
      dm_rsp_rdata_q <= dm_rsp_rdata_d;
      arb_err_q      <= arb_err_d;
    end
  end

  assign if_rsp_valid = if_rsp_valid_q;
  assign if_rsp_data  = if_rsp_data_q;
  assign dm_rsp_valid = dm_rsp_valid_q;
  assign dm_rsp_rdata = dm_rsp_rdata_q;
  assign arb_err      = arb_err_q;
  assign dbg_state    = state_q;

endmodule
